// File: rtl/memory_stage_if.sv
// memory_stage_if: execute-to-memory pipeline bus for memory_stage.
//   I*            : instruction fields launched by the execute stage
//   *MEM outputs  : EX/MEM contents fed back to the hazard/forwarding logic
//   loadDataWB,
//   ORegWrite, ORd: MEM/WB write-back port toward the register file
// master modport is the execute side, slave modport is memory_stage.
interface memory_stage_if;
  localparam int unsigned DataW = 16;
  localparam int unsigned RegW  = 3;
  localparam int unsigned SelW  = 2;

  logic             IRegWrite;
  logic [SelW-1:0]  IRegStore;
  logic             IMemWrite;
  logic             IMemRead;
  logic [DataW-1:0] IPCP2;
  logic [DataW-1:0] IALUResult;
  logic [DataW-1:0] I3rdArg;
  logic [RegW-1:0]  IRd;
  logic             IFlush;

  logic [DataW-1:0] ALUResultMEM;
  logic [RegW-1:0]  ORdMEM;
  logic             ORegWriteMEM;
  logic             OMemReadMEM;
  logic [DataW-1:0] loadDataWB;
  logic             ORegWrite;
  logic [RegW-1:0]  ORd;

  modport master (
    output IRegWrite, IRegStore, IMemWrite, IMemRead, IPCP2, IALUResult,
           I3rdArg, IRd, IFlush,
    input  ALUResultMEM, ORdMEM, ORegWriteMEM, OMemReadMEM, loadDataWB,
           ORegWrite, ORd
  );

  modport slave (
    input  IRegWrite, IRegStore, IMemWrite, IMemRead, IPCP2, IALUResult,
           I3rdArg, IRd, IFlush,
    output ALUResultMEM, ORdMEM, ORegWriteMEM, OMemReadMEM, loadDataWB,
           ORegWrite, ORd
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, 1024x16 data memory and MEM/WB register.
//   clk   : single clock, rising edge
//   reset : synchronous active-high; clears both pipeline registers and
//           blocks the memory write at that edge (memory contents kept)
//   bus   : memory_stage_if.slave (instruction in, forwarding and
//           write-back controls out)
module memory_stage (
  input  logic          clk,
  input  logic          reset,
  memory_stage_if.slave bus
);
  localparam int unsigned DataW    = 16;
  localparam int unsigned RegW     = 3;
  localparam int unsigned SelW     = 2;
  localparam int unsigned AddrW    = 10;
  localparam int unsigned MemDepth = 1024;

  localparam logic [SelW-1:0] SelAlu  = 2'b00;
  localparam logic [SelW-1:0] SelLoad = 2'b01;
  localparam logic [SelW-1:0] SelPc   = 2'b10;

  typedef struct packed {
    logic             reg_write;
    logic [SelW-1:0]  reg_store;
    logic             mem_write;
    logic             mem_read;
    logic [RegW-1:0]  rd;
    logic [DataW-1:0] pcp2;
    logic [DataW-1:0] alu_result;
    logic [DataW-1:0] third_arg;
  } ex_mem_t;

  typedef struct packed {
    logic             reg_write;
    logic [SelW-1:0]  reg_store;
    logic [RegW-1:0]  rd;
    logic [DataW-1:0] alu_result;
    logic [DataW-1:0] pcp2;
    logic [DataW-1:0] load_data;
  } mem_wb_t;

  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  logic [DataW-1:0] dmem [MemDepth];
  logic [AddrW-1:0] dmem_addr;
  logic [DataW-1:0] dmem_rdata;
  logic             dmem_we;
  logic [DataW-1:0] wb_data;
  logic             unused_addr_bits;

  // Word address: byte bit 0 and bits above the 2 KiB window are dropped.
  assign dmem_addr        = ex_mem_q.alu_result[AddrW:1];
  assign unused_addr_bits = ^{ex_mem_q.alu_result[DataW-1:AddrW+1],
                              ex_mem_q.alu_result[0]};
  assign dmem_rdata       = dmem[dmem_addr];
  assign dmem_we          = ex_mem_q.mem_write & ~reset;

  // EX/MEM next state; a flush keeps the data but kills every control bit.
  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = bus.IRegWrite;
    ex_mem_d.reg_store  = bus.IRegStore;
    ex_mem_d.mem_write  = bus.IMemWrite;
    ex_mem_d.mem_read   = bus.IMemRead;
    ex_mem_d.rd         = bus.IRd;
    ex_mem_d.pcp2       = bus.IPCP2;
    ex_mem_d.alu_result = bus.IALUResult;
    ex_mem_d.third_arg  = bus.I3rdArg;
    if (bus.IFlush) begin
      ex_mem_d.reg_write = 1'b0;
      ex_mem_d.reg_store = '0;
      ex_mem_d.mem_write = 1'b0;
      ex_mem_d.mem_read  = 1'b0;
    end
  end

  // MEM/WB next state; the load field only moves on a load, so it reads
  // the pre-write word when a load and store share the cycle.
  always_comb begin
    mem_wb_d            = '0;
    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.reg_store  = ex_mem_q.reg_store;
    mem_wb_d.rd         = ex_mem_q.rd;
    mem_wb_d.alu_result = ex_mem_q.alu_result;
    mem_wb_d.pcp2       = ex_mem_q.pcp2;
    mem_wb_d.load_data  = ex_mem_q.mem_read ? dmem_rdata : mem_wb_q.load_data;
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Data memory write port; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (dmem_we) begin
      dmem[dmem_addr] <= ex_mem_q.third_arg;
    end
  end

  // Write-back source select.
  always_comb begin
    wb_data = '0;
    unique case (mem_wb_q.reg_store)
      SelAlu:  wb_data = mem_wb_q.alu_result;
      SelLoad: wb_data = mem_wb_q.load_data;
      SelPc:   wb_data = mem_wb_q.pcp2;
      default: wb_data = '0;
    endcase
  end

  assign bus.ALUResultMEM = ex_mem_q.alu_result;
  assign bus.ORdMEM       = ex_mem_q.rd;
  assign bus.ORegWriteMEM = ex_mem_q.reg_write;
  assign bus.OMemReadMEM  = ex_mem_q.mem_read;
  assign bus.loadDataWB   = wb_data;
  assign bus.ORegWrite    = mem_wb_q.reg_write;
  assign bus.ORd          = mem_wb_q.rd;
endmodule
